// File: rtl/ifm_window_sequencer.sv
// ifm_window_sequencer: streams one IFM out of IFM RAM in raster order, drives the
// 5x5 line-buffer shift enable and flags the cycles where the taps hold a complete,
// non-wrapping KERNAL_SIZE x KERNAL_SIZE window, with its output-map address.
// Optional feature macro: WINDOW_SEQ_COUNT_EN adds the window_count output.
module ifm_window_sequencer #(
   parameter int unsigned IFM_SIZE              = 14,
   parameter int unsigned KERNAL_SIZE           = 5,
   parameter int unsigned IFM_SIZE_NEXT         = IFM_SIZE - KERNAL_SIZE + 1,
   parameter int unsigned ADDRESS_SIZE_IFM      = $clog2(IFM_SIZE * IFM_SIZE),
   parameter int unsigned ADDRESS_SIZE_NEXT_IFM = $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             start,
   input  logic                             pause,
   output logic                             busy,
   output logic                             done,
   output logic                             ifm_rd_en,
   output logic [ADDRESS_SIZE_IFM-1:0]      ifm_address,
   output logic                             fifo_enable,
   output logic                             window_valid,
   output logic [ADDRESS_SIZE_NEXT_IFM-1:0] ofm_address
`ifdef WINDOW_SEQ_COUNT_EN
   ,
   output logic [ADDRESS_SIZE_NEXT_IFM:0]   window_count
`endif
);

   // Read pointer is one bit wider than the RAM address so it can hold IFM_SIZE^2.
   localparam int unsigned PTR_W = ADDRESS_SIZE_IFM + 1;
   // Row/col push counters; row runs one past the last row after the final push.
   localparam int unsigned RC_W  = $clog2(IFM_SIZE + 1);

   localparam logic [PTR_W-1:0] LAST_ADDR = PTR_W'(IFM_SIZE * IFM_SIZE - 1);
   localparam logic [RC_W-1:0]  LAST_COL  = RC_W'(IFM_SIZE - 1);
   localparam logic [RC_W-1:0]  FIRST_WIN = RC_W'(KERNAL_SIZE - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                      state, state_next;
   logic [PTR_W-1:0]            rd_ptr, rd_ptr_next;
   logic [ADDRESS_SIZE_IFM-1:0] address_next;
   logic                        rd_en_next;
   logic                        done_next;
   logic                        busy_next;
   logic                        start_accept;
   logic [RC_W-1:0]             row, col;

   // State and registered control outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         rd_ptr      <= '0;
         ifm_rd_en   <= 1'b0;
         ifm_address <= '0;
         done        <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_next;
         rd_ptr      <= rd_ptr_next;
         ifm_rd_en   <= rd_en_next;
         ifm_address <= address_next;
         done        <= done_next;
         busy        <= busy_next;
      end
   end

   // Next state and next values of the control outputs; rd_ptr holds the next address to issue.
   always_comb begin
      state_next   = state;
      rd_ptr_next  = rd_ptr;
      rd_en_next   = 1'b0;
      address_next = ifm_address;
      done_next    = 1'b0;
      start_accept = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next   = READ;
               start_accept = 1'b1;
               rd_en_next   = 1'b1;
               address_next = '0;
               rd_ptr_next  = PTR_W'(1);
            end
         end
         READ: begin
            address_next = ADDRESS_SIZE_IFM'(rd_ptr);
            if (!pause) begin
               rd_en_next  = 1'b1;
               rd_ptr_next = rd_ptr + PTR_W'(1);
               if (rd_ptr == LAST_ADDR) begin
                  state_next = DRAIN;
               end
            end
         end
         DRAIN: begin
            // Last read has landed, been pushed and had its window flagged.
            if (!ifm_rd_en && !fifo_enable) begin
               state_next = DONE;
               done_next  = 1'b1;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      busy_next = (state_next != IDLE);
   end

   // Push tracking: shift enable follows the 1-cycle RAM latency, row/col locate each push.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fifo_enable  <= 1'b0;
         window_valid <= 1'b0;
         row          <= '0;
         col          <= '0;
         ofm_address  <= '0;
      end else begin
         fifo_enable  <= ifm_rd_en;
         window_valid <= fifo_enable && (row >= FIRST_WIN) && (col >= FIRST_WIN);
         if (start_accept) begin
            row         <= '0;
            col         <= '0;
            ofm_address <= '0;
         end else begin
            if (fifo_enable) begin
               if (col == LAST_COL) begin
                  col <= '0;
                  row <= row + RC_W'(1);
               end else begin
                  col <= col + RC_W'(1);
               end
            end
            if (window_valid) begin
               ofm_address <= ofm_address + ADDRESS_SIZE_NEXT_IFM'(1);
            end
         end
      end
   end

`ifdef WINDOW_SEQ_COUNT_EN
   // Count of valid windows in the current map; holds through IDLE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         window_count <= '0;
      end else if (start_accept) begin
         window_count <= '0;
      end else if (window_valid) begin
         window_count <= window_count + (ADDRESS_SIZE_NEXT_IFM + 1)'(1);
      end
   end
`endif

endmodule

// File: tb/tb_ifm_window_sequencer.sv
// Bench for ifm_window_sequencer: cycle-indexed reference waveform built from the
// raster/window rules, checked every cycle of each map, plus hand-computed pins.
// Build with WINDOW_SEQ_COUNT_EN defined to also cover window_count.
module tb_ifm_window_sequencer;

   localparam int N    = 14;
   localparam int K    = 5;
   localparam int NN   = N * N;
   localparam int AW   = $clog2(NN);
   localparam int OW   = $clog2((N - K + 1) * (N - K + 1));
   localparam int MAXK = 260;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          pause;
   logic          busy, done, ifm_rd_en, fifo_enable, window_valid;
   logic [AW-1:0] ifm_address;
   logic [OW-1:0] ofm_address;
`ifdef WINDOW_SEQ_COUNT_EN
   logic [OW:0]   window_count;
`endif

   ifm_window_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .pause        (pause),
      .busy         (busy),
      .done         (done),
      .ifm_rd_en    (ifm_rd_en),
      .ifm_address  (ifm_address),
      .fifo_enable  (fifo_enable),
      .window_valid (window_valid),
      .ofm_address  (ofm_address)
`ifdef WINDOW_SEQ_COUNT_EN
      ,
      .window_count (window_count)
`endif
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int kc     = 0;
   bit run_active = 1'b0;
   int scen   = 0;

   // Reference waveform, index k = cycles after the start edge T.
   bit e_rd   [MAXK];
   int e_addr [MAXK];
   bit e_fifo [MAXK];
   bit e_wv   [MAXK];
   int e_ofm  [MAXK];
   int e_cnt  [MAXK];
   bit e_done [MAXK];
   bit e_busy [MAXK];
   int done_k;
   int mp0, mplen;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s k=%0d actual=%0d expected=%0d", name, kc, act, exp);
      end
   endtask

   // Raster reads with a pause window [p0, p0+plen) of edges, then windows from push row/col.
   task automatic build_model(input int p0, input int plen);
      int a, push, nwin, last_issue;
      a = 0; push = 0; nwin = 0; last_issue = 0;
      mp0 = p0; mplen = plen;
      for (int k = 0; k < MAXK; k++) begin
         e_rd[k] = 0; e_addr[k] = 0; e_fifo[k] = 0; e_wv[k] = 0;
         e_ofm[k] = 0; e_cnt[k] = 0; e_done[k] = 0; e_busy[k] = 0;
      end
      for (int k = 0; k < MAXK; k++) begin
         if (a < NN) begin
            e_addr[k] = a;
            if (!(k >= p0 && k < p0 + plen)) begin
               e_rd[k] = 1; last_issue = k; a++;
            end
         end
      end
      for (int k = 1; k < MAXK; k++) e_fifo[k] = e_rd[k-1];
      for (int k = 1; k < MAXK; k++) begin
         if (e_fifo[k-1]) begin
            if ((push / N) >= K - 1 && (push % N) >= K - 1) e_wv[k] = 1;
            push++;
         end
         e_ofm[k] = nwin;
         e_cnt[k] = nwin;
         if (e_wv[k]) nwin++;
      end
      done_k = last_issue + 3;
      for (int k = 0; k < MAXK; k++) e_busy[k] = (k <= done_k);
      e_done[done_k] = 1;
   endtask

   // Per-cycle comparison against the reference waveform while a map is running.
   always @(negedge clk) begin
      if (run_active) begin
         if (kc < MAXK) begin
            chk("ifm_rd_en", ifm_rd_en, e_rd[kc]);
            if (e_rd[kc] || (kc >= mp0 && kc < mp0 + mplen))
               chk("ifm_address", ifm_address, e_addr[kc]);
            chk("fifo_enable", fifo_enable, e_fifo[kc]);
            chk("window_valid", window_valid, e_wv[kc]);
            chk("ofm_address", ofm_address, e_ofm[kc]);
            chk("done", done, e_done[kc]);
            chk("busy", busy, e_busy[kc]);
`ifdef WINDOW_SEQ_COUNT_EN
            chk("window_count", window_count, e_cnt[kc]);
`endif
            if (scen == 0 && kc == 62) begin
               chk("first_window_lit", window_valid, 1);
               chk("first_ofm_lit", ofm_address, 0);
            end
            if (scen == 0 && kc == 72) chk("wrap_p70_lit", window_valid, 0);
            if (scen == 0 && kc == 76) chk("ofm_p74_lit", ofm_address, 10);
            if (scen == 0 && kc == 198) chk("done_t198_lit", done, 1);
            if (scen == 1 && kc >= 51 && kc <= 53) begin
               chk("pause_addr_lit", ifm_address, 51);
               chk("pause_rd_lit", ifm_rd_en, 0);
            end
            if (scen == 1 && kc == 201) chk("done_t201_lit", done, 1);
         end
         kc++;
      end else begin
         kc = 0;
      end
   end

   task automatic check_all_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_rd_en"}, ifm_rd_en, 0);
      chk({tag, "_address"}, ifm_address, 0);
      chk({tag, "_fifo_enable"}, fifo_enable, 0);
      chk({tag, "_window_valid"}, window_valid, 0);
      chk({tag, "_ofm_address"}, ofm_address, 0);
`ifdef WINDOW_SEQ_COUNT_EN
      chk({tag, "_window_count"}, window_count, 0);
`endif
   endtask

   // One map: start at edge T, optional pause window, optional stray start, optional reset.
   task automatic do_run(input int p0, input int plen, input int restart_at, input int reset_at);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      run_active = 1'b1;
      for (int j = 1; j <= done_k + 3; j++) begin
         @(posedge clk);
         #1;
         pause = (j + 1 >= p0 && j + 1 < p0 + plen);
         start = (j + 1 == restart_at);
         if (j == reset_at) begin
            @(negedge clk);
            #1;
            run_active = 1'b0;
            reset = 1'b1;
            #1;
            check_all_zero("mid_reset");
            break;
         end
      end
      run_active = 1'b0;
      pause = 1'b0;
      start = 1'b0;
   endtask

   initial begin
      int first, last, tot;
      reset = 1'b1;
      start = 1'b0;
      pause = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      reset = 1'b0;
      repeat (2) @(posedge clk);

      // Plain map, no pause; pin the reference against hand-computed values first.
      scen = 0;
      build_model(0, 0);
      first = -1; last = -1; tot = 0;
      for (int k = 0; k < MAXK; k++) begin
         if (e_wv[k]) begin
            if (first < 0) first = k;
            last = k;
            tot++;
         end
      end
      chk("model_first_wv", first, 62);
      chk("model_last_wv", last, 197);
      chk("model_windows", tot, 100);
      chk("model_done", done_k, 198);
      chk("model_ofm_p74", e_ofm[76], 10);
      chk("model_last_ofm", e_ofm[197], 99);
      do_run(0, 0, -1, -1);
      repeat (2) @(posedge clk);

      // Three paused edges right after address 50 is issued.
      scen = 1;
      build_model(51, 3);
      chk("model_done_pause", done_k, 201);
      do_run(51, 3, -1, -1);
      repeat (2) @(posedge clk);

      // Stray start during READ must change nothing.
      scen = 2;
      build_model(0, 0);
      do_run(0, 0, 30, -1);
      repeat (2) @(posedge clk);

      // Reset in the middle of READ, after address 120 is issued.
      scen = 3;
      build_model(0, 0);
      do_run(0, 0, -1, 120);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (2) @(posedge clk);

      // Fresh map after the reset restarts from address 0 / ofm 0.
      scen = 4;
      build_model(0, 0);
      do_run(0, 0, -1, -1);
      repeat (5) @(posedge clk);
      #1;
      chk("idle_busy", busy, 0);
`ifdef WINDOW_SEQ_COUNT_EN
      chk("idle_window_count", window_count, 100);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
